usb2_ep_sched: RTL and testbench

Transaction scheduler between the USB 2.0 packet layer and the endpoint blocks (ep0 control, ep1 IN, ep2 OUT).
- Captures endpoint-ready edges into per-endpoint latches.
- Decides dispatch, NAK or STALL for each decoded token.
- Owns the per-endpoint DATA0/DATA1 toggle.
- Sequences xfer_in/xfer_out toward the selected endpoint and retires the transfer on handshake.
- Direction naming: xfer_in = host-to-device data (OUT/SETUP token); xfer_out = device-to-host data (IN token).

---
 rtl/usb2_ep_sched.sv | 188 ++++++++++++++++++
 tb/tb_usb2_ep_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ep_sched.sv
// USB 2.0 transaction scheduler: turns decoded tokens into dispatch/NAK/STALL decisions,
// owns the per-endpoint data toggles and sequences one data phase at a time.
module usb2_ep_sched #(
   parameter int unsigned NUM_EP  = 3,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic              i_phy_clk,
   input  logic              i_reset,
   input  logic              i_se0_reset,
   input  logic              i_token_valid,
   input  logic [3:0]        i_token_pid,
   input  logic [3:0]        i_token_endp,
   input  logic [NUM_EP-1:0] i_ep_ready,
   input  logic              i_xfer_done,
   input  logic              i_xfer_ack,
   output logic              o_xfer_in,
   output logic              o_xfer_out,
   output logic [3:0]        o_xfer_endp,
   output logic [3:0]        o_xfer_pid,
   output logic              o_resp_nak,
   output logic              o_resp_stall,
   output logic              o_busy,
   output logic [NUM_EP-1:0] o_ep_ready_latch,
   output logic              o_err_missed_ep_ready,
   output logic              o_err_timeout,
   output logic              o_err_token_overrun
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [1:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic [NUM_EP-1:0] r_ep_ready_prev;
   logic [NUM_EP-1:0] r_latch;
   logic [NUM_EP-1:0] r_toggle;
   logic              r_xfer_in;
   logic              r_xfer_out;
   logic [3:0]        r_xfer_endp;
   logic [3:0]        r_xfer_pid;
   logic              r_resp_nak;
   logic              r_resp_stall;
   logic              r_err_missed;
   logic              r_err_timeout;
   logic              r_err_overrun;

   logic [NUM_EP-1:0] w_rise;
   logic [NUM_EP-1:0] w_sel_mask;
   logic [NUM_EP-1:0] w_clr;
   logic [15:0]       w_latch16;
   logic [15:0]       w_toggle16;
   logic              w_endp_ok;
   logic              w_tok_latch;
   logic              w_tok_toggle;
   logic              w_ack;

   // Ready edges are swallowed while the bus is held in reset.
   assign w_rise       = i_ep_ready & ~r_ep_ready_prev & {NUM_EP{~i_se0_reset}};
   assign w_latch16    = {{(16 - NUM_EP){1'b0}}, r_latch};
   assign w_toggle16   = {{(16 - NUM_EP){1'b0}}, r_toggle};
   assign w_endp_ok    = ({28'd0, i_token_endp} < NUM_EP);
   assign w_tok_latch  = w_latch16[i_token_endp];
   assign w_tok_toggle = w_toggle16[i_token_endp];
   assign w_ack        = (r_state == ST_XFER) & i_xfer_done & i_xfer_ack;
   assign w_clr        = w_sel_mask & {NUM_EP{w_ack}};

   always_comb begin
      w_sel_mask = '0;
      for (int e = 0; e < NUM_EP; e++) begin
         w_sel_mask[e] = (r_xfer_endp == 4'(e));
      end
   end

   always_ff @(posedge i_phy_clk) begin
      if (i_reset) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         r_ep_ready_prev <= '0;
         r_latch         <= '0;
         r_toggle        <= '0;
         r_xfer_in       <= 1'b0;
         r_xfer_out      <= 1'b0;
         r_xfer_endp     <= 4'd0;
         r_xfer_pid      <= 4'd0;
         r_resp_nak      <= 1'b0;
         r_resp_stall    <= 1'b0;
         r_err_missed    <= 1'b0;
         r_err_timeout   <= 1'b0;
         r_err_overrun   <= 1'b0;
      end else begin
         r_ep_ready_prev <= i_ep_ready;
         r_resp_nak      <= 1'b0;
         r_resp_stall    <= 1'b0;
         if (|(w_rise & r_latch)) r_err_missed <= 1'b1;
         if (i_token_valid && (r_state != ST_IDLE)) r_err_overrun <= 1'b1;

         if (i_se0_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_latch     <= '0;
            r_toggle    <= '0;
            r_xfer_in   <= 1'b0;
            r_xfer_out  <= 1'b0;
            r_xfer_endp <= 4'd0;
            r_xfer_pid  <= 4'd0;
         end else begin
            // Set wins over a same-cycle retire clear.
            r_latch <= (r_latch & ~w_clr) | w_rise;
            case (r_state)
               ST_IDLE: begin
                  if (i_token_valid) begin
                     if (!w_endp_ok) begin
                        r_resp_stall <= 1'b1;
                     end else begin
                        case (i_token_pid)
                           PID_SETUP: begin
                              if (i_token_endp == 4'd0) begin
                                 r_toggle[0] <= 1'b0;
                                 r_xfer_in   <= 1'b1;
                                 r_xfer_pid  <= PID_DATA0;
                                 r_xfer_endp <= i_token_endp;
                                 r_state     <= ST_XFER;
                              end else begin
                                 r_resp_stall <= 1'b1;
                              end
                           end
                           PID_IN, PID_OUT: begin
                              if (w_tok_latch) begin
                                 r_xfer_in   <= (i_token_pid == PID_OUT);
                                 r_xfer_out  <= (i_token_pid == PID_IN);
                                 r_xfer_pid  <= w_tok_toggle ? PID_DATA1 : PID_DATA0;
                                 r_xfer_endp <= i_token_endp;
                                 r_state     <= ST_XFER;
                              end else begin
                                 r_resp_nak <= 1'b1;
                              end
                           end
                           default: ;
                        endcase
                     end
                  end
               end
               ST_XFER: begin
                  if (i_xfer_done || (r_cnt == CW'(TIMEOUT - 1))) begin
                     // SETUP forced toggle[0] to 0, so the flip leaves it at 1.
                     if (w_ack) r_toggle <= r_toggle ^ w_sel_mask;
                     if (!i_xfer_done) r_err_timeout <= 1'b1;
                     r_xfer_in   <= 1'b0;
                     r_xfer_out  <= 1'b0;
                     r_xfer_endp <= 4'd0;
                     r_xfer_pid  <= 4'd0;
                     r_state     <= ST_DONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_DONE: begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_xfer_in             = r_xfer_in;
   assign o_xfer_out            = r_xfer_out;
   assign o_xfer_endp           = r_xfer_endp;
   assign o_xfer_pid            = r_xfer_pid;
   assign o_resp_nak            = r_resp_nak;
   assign o_resp_stall          = r_resp_stall;
   assign o_busy                = (r_state != ST_IDLE);
   assign o_ep_ready_latch      = r_latch;
   assign o_err_missed_ep_ready = r_err_missed;
   assign o_err_timeout         = r_err_timeout;
   assign o_err_token_overrun   = r_err_overrun;

endmodule

// File: tb/tb_usb2_ep_sched.sv
// Directed bench for usb2_ep_sched; expected values are hand-derived per scenario.
module tb_usb2_ep_sched;

   localparam logic [3:0] IN    = 4'b1001;
   localparam logic [3:0] OUT   = 4'b0001;
   localparam logic [3:0] SETUP = 4'b1101;
   localparam logic [3:0] D0    = 4'b0011;
   localparam logic [3:0] D1    = 4'b1011;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       se0 = 1'b0;
   logic       tok_v = 1'b0;
   logic [3:0] tok_pid = 4'd0;
   logic [3:0] tok_endp = 4'd0;
   logic [2:0] ep_ready = 3'd0;
   logic       done = 1'b0;
   logic       ack = 1'b0;
   logic       xin, xout, nak, stall, busy, e_miss, e_to, e_ovr;
   logic [3:0] xendp, xpid;
   logic [2:0] latch;

   int n_checks = 0;
   int n_errors = 0;

   usb2_ep_sched #(.NUM_EP(3), .TIMEOUT(1023)) dut (
      .i_phy_clk             (clk),
      .i_reset               (reset),
      .i_se0_reset           (se0),
      .i_token_valid         (tok_v),
      .i_token_pid           (tok_pid),
      .i_token_endp          (tok_endp),
      .i_ep_ready            (ep_ready),
      .i_xfer_done           (done),
      .i_xfer_ack            (ack),
      .o_xfer_in             (xin),
      .o_xfer_out            (xout),
      .o_xfer_endp           (xendp),
      .o_xfer_pid            (xpid),
      .o_resp_nak            (nak),
      .o_resp_stall          (stall),
      .o_busy                (busy),
      .o_ep_ready_latch      (latch),
      .o_err_missed_ep_ready (e_miss),
      .o_err_timeout         (e_to),
      .o_err_token_overrun   (e_ovr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic token(input logic [3:0] pid, input logic [3:0] endp);
      tok_v = 1'b1; tok_pid = pid; tok_endp = endp;
      tick();
      tok_v = 1'b0;
   endtask

   // Ends a data phase; returns sampled one cycle after the done pulse (state DONE).
   task automatic finish_xfer(input logic a);
      done = 1'b1; ack = a;
      tick();
      done = 1'b0; ack = 1'b0;
   endtask

   task automatic ready_edge(input int e);
      ep_ready[e] = 1'b0;
      tick();
      ep_ready[e] = 1'b1;
      tick(2);
   endtask

   initial begin
      int n;
      tick(2);
      check("rst_xin", xin, 0);
      check("rst_xout", xout, 0);
      check("rst_endp", xendp, 0);
      check("rst_pid", xpid, 0);
      check("rst_busy", busy, 0);
      check("rst_latch", latch, 0);
      check("rst_errs", {e_miss, e_to, e_ovr, nak, stall}, 0);
      reset = 1'b0;
      tick();

      // 1: OUT to ep2, toggle advances after ACK
      ready_edge(2);
      check("t1_latch", latch, 3'b100);
      token(OUT, 4'd2);
      check("t1_xin", xin, 1);
      check("t1_endp", xendp, 2);
      check("t1_pid", xpid, D0);
      check("t1_busy", busy, 1);
      finish_xfer(1'b1);
      check("t1_xin_fall", xin, 0);
      check("t1_latch_clr", latch, 3'b000);
      check("t1_done_busy", busy, 1);
      tick();
      check("t1_idle", busy, 0);
      ready_edge(2);
      token(OUT, 4'd2);
      check("t1_pid2", xpid, D1);
      finish_xfer(1'b1);
      tick();
      ep_ready[2] = 1'b0;

      // 2: NAK, then un-ACKed IN retried with same PID
      token(IN, 4'd1);
      check("t2_nak", nak, 1);
      check("t2_nak_busy", busy, 0);
      tick();
      check("t2_nak_pulse", nak, 0);
      ready_edge(1);
      token(IN, 4'd1);
      check("t2_xout", xout, 1);
      check("t2_pid", xpid, D0);
      finish_xfer(1'b0);
      check("t2_xout_fall", xout, 0);
      tick();
      check("t2_latch_kept", latch, 3'b010);
      token(IN, 4'd1);
      check("t2_pid_retry", xpid, D0);
      finish_xfer(1'b1);
      tick();
      check("t2_latch_clr", latch, 3'b000);

      // 3: SETUP resets toggle[0], STALL cases
      ready_edge(0);
      token(OUT, 4'd0);
      check("t3_out0_pid", xpid, D0);
      finish_xfer(1'b1);
      tick();
      token(SETUP, 4'd0);
      check("t3_setup_xin", xin, 1);
      check("t3_setup_pid", xpid, D0);
      check("t3_setup_endp", xendp, 0);
      check("t3_setup_busy", busy, 1);
      finish_xfer(1'b1);
      tick();
      ready_edge(0);
      token(OUT, 4'd0);
      check("t3_after_setup_pid", xpid, D1);
      finish_xfer(1'b1);
      tick();
      token(SETUP, 4'd1);
      check("t3_setup1_stall", stall, 1);
      check("t3_setup1_busy", busy, 0);
      tick();
      token(OUT, 4'd5);
      check("t3_ep5_stall", stall, 1);
      check("t3_ep5_busy", busy, 0);
      tick();

      // 4: missed ready edge, token overrun
      check("t4_miss_pre", e_miss, 0);
      ready_edge(0);
      ready_edge(0);
      check("t4_miss", e_miss, 1);
      token(IN, 4'd0);
      check("t4_pid", xpid, D0);
      token(OUT, 4'd2);
      check("t4_ovr", e_ovr, 1);
      check("t4_xout_kept", xout, 1);
      check("t4_endp_kept", xendp, 0);
      finish_xfer(1'b1);
      tick();

      // 5: timeout after 1023 XFER cycles
      ready_edge(1);
      token(IN, 4'd1);
      check("t5_pid", xpid, D1);
      n = 0;
      while (!e_to && n < 1100) begin
         tick();
         n++;
      end
      check("t5_cycles", n, 1023);
      check("t5_err", e_to, 1);
      check("t5_xout", xout, 0);
      check("t5_latch", latch, 3'b010);
      tick();
      check("t5_busy", busy, 0);

      // 6: bus reset mid-transfer, then hard reset mid-transfer
      token(OUT, 4'd1);
      check("t6_xin", xin, 1);
      check("t6_pid", xpid, D1);
      se0 = 1'b1;
      tick();
      se0 = 1'b0;
      check("t6_se0_xin", xin, 0);
      check("t6_se0_busy", busy, 0);
      check("t6_se0_latch", latch, 3'b000);
      check("t6_se0_errs", {e_miss, e_to, e_ovr}, 3'b111);
      ready_edge(1);
      token(OUT, 4'd1);
      check("t6_toggle_clr", xpid, D0);
      reset = 1'b1;
      tick();
      check("t6_rst_outs", {xin, xout, xendp, xpid, nak, stall, busy}, 0);
      check("t6_rst_latch", latch, 0);
      check("t6_rst_errs", {e_miss, e_to, e_ovr}, 0);
      reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
